// File: rtl/burger_pkg.sv
// Shared types and constants for the burger ingredient logic.
package burger_pkg;

    localparam int PIX_W  = 10;
    localparam int CHEF_W = 16;
    localparam int CHEF_H = 16;

    // One extra bit so that position sums never wrap.
    typedef logic [PIX_W:0] pix_ext_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DROP   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ingredient_drop_ctrl_seg_hit_detect.sv
// Combinational chef-on-ingredient test: row match and per-segment hit vector.
module seg_hit_detect
    import burger_pkg::*;
#(
    parameter int NUM_SEG = 4,
    parameter int SEG_W   = 8,
    parameter int ROW_TOL = 2
) (
    input  logic [PIX_W-1:0]   chef_x_i,
    input  logic [PIX_W-1:0]   chef_y_i,
    input  logic [PIX_W-1:0]   ingr_x_i,
    input  logic [PIX_W-1:0]   ingr_y_i,
    output logic               on_row_o,
    output logic [NUM_SEG-1:0] hit_o
);

    pix_ext_t feet_y;
    pix_ext_t centre_x;
    pix_ext_t ingr_x_ext;
    pix_ext_t ingr_y_ext;

    assign feet_y     = {1'b0, chef_y_i} + pix_ext_t'(CHEF_H);
    assign centre_x   = {1'b0, chef_x_i} + pix_ext_t'(CHEF_W / 2);
    assign ingr_x_ext = {1'b0, ingr_x_i};
    assign ingr_y_ext = {1'b0, ingr_y_i};

    // Feet may sit up to ROW_TOL pixels below the ingredient top.
    assign on_row_o = (ingr_y_ext <= feet_y) &&
                      (feet_y <= ingr_y_ext + pix_ext_t'(ROW_TOL));

    generate
        for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
            pix_ext_t seg_lo;
            pix_ext_t seg_hi;
            assign seg_lo    = ingr_x_ext + pix_ext_t'(gi * SEG_W);
            assign seg_hi    = ingr_x_ext + pix_ext_t'((gi + 1) * SEG_W - 1);
            assign hit_o[gi] = on_row_o && (seg_lo <= centre_x) && (centre_x <= seg_hi);
        end
    endgenerate

endmodule

// File: rtl/ingredient_drop_ctrl.sv
// Per-ingredient drop controller: segment stepping, cascade, drop and settle.
// Optional build macro DROP_SCORE_EN adds a score pulse on each drop start.
module ingredient_drop_ctrl
    import burger_pkg::*;
#(
    parameter int NUM_SEG      = 4,
    parameter int SEG_W        = 8,
    parameter int ROW_TOL      = 2,
    parameter int ING_H        = 4,
    parameter int DROP_DIST    = 32,
    parameter int DROP_TIMEOUT = 255
) (
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [PIX_W-1:0]   ChefX,
    input  logic [PIX_W-1:0]   ChefY,
    input  logic [PIX_W-1:0]   IngrX,
    input  logic [PIX_W-1:0]   IngrY,
    input  logic               ingr_finish,
    input  logic               above_falling,
    input  logic [PIX_W-1:0]   AboveY,
    output logic               fall,
    output logic [NUM_SEG-1:0] seg_stepped,
    output logic               busy,
    output logic               done,
    output logic               score_pulse
);

    localparam int TIMER_W = $clog2(DROP_TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [NUM_SEG-1:0]   seg_q, seg_d;
    logic [PIX_W-1:0]     start_y_q, start_y_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;

    logic                 on_row;
    logic [NUM_SEG-1:0]   hit;
    logic                 cascade;
    logic                 drop_reached;
    logic                 enter_drop;

    seg_hit_detect #(
        .NUM_SEG (NUM_SEG),
        .SEG_W   (SEG_W),
        .ROW_TOL (ROW_TOL)
    ) u_hit (
        .chef_x_i (ChefX),
        .chef_y_i (ChefY),
        .ingr_x_i (IngrX),
        .ingr_y_i (IngrY),
        .on_row_o (on_row),
        .hit_o    (hit)
    );

    assign cascade = above_falling &&
                     ({1'b0, AboveY} + pix_ext_t'(ING_H) >= {1'b0, IngrY}) &&
                     ({1'b0, AboveY} <= {1'b0, IngrY});

    assign drop_reached = {1'b0, IngrY} >= {1'b0, start_y_q} + pix_ext_t'(DROP_DIST);

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        start_y_d = start_y_q;
        timer_d   = timer_q;
        case (state_q)
            IDLE: begin
                seg_d = seg_q | hit;
                if (ingr_finish) begin
                    state_d = DONE;
                    seg_d   = '0;
                end else if (cascade || (&(seg_q | hit))) begin
                    state_d   = DROP;
                    start_y_d = IngrY;
                    timer_d   = '0;
                end
            end
            DROP: begin
                timer_d = timer_q + 1'b1;
                if (ingr_finish) begin
                    state_d = DONE;
                    seg_d   = '0;
                end else if (drop_reached || (timer_q == TIMER_W'(DROP_TIMEOUT))) begin
                    state_d = SETTLE;
                    seg_d   = '0;
                end
            end
            SETTLE: begin
                // Any cascade seen here is picked up again once back in IDLE.
                seg_d   = '0;
                state_d = IDLE;
            end
            DONE: begin
                seg_d = '0;
            end
            default: begin
                state_d = IDLE;
                seg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            seg_q     <= '0;
            start_y_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            start_y_q <= start_y_d;
            timer_q   <= timer_d;
        end
    end

    assign enter_drop  = (state_q == IDLE) && (state_d == DROP);
    assign fall        = (state_q == DROP);
    assign busy        = (state_q == DROP) || (state_q == SETTLE);
    assign done        = (state_q == DONE);
    assign seg_stepped = seg_q;

`ifdef DROP_SCORE_EN
    logic       score_q;
    logic [7:0] cascade_cnt_q;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            score_q       <= 1'b0;
            cascade_cnt_q <= '0;
        end else begin
            score_q <= enter_drop;
            if (enter_drop && cascade && (cascade_cnt_q != 8'hFF)) begin
                cascade_cnt_q <= cascade_cnt_q + 8'd1;
            end
        end
    end

    assign score_pulse = score_q;
`else
    logic unused_enter_drop;
    assign unused_enter_drop = enter_drop;
    assign score_pulse       = 1'b0;
`endif

    logic unused_on_row;
    assign unused_on_row = on_row;

endmodule

// File: tb/tb_ingredient_drop_ctrl.sv
// Directed scoreboard bench for ingredient_drop_ctrl (honours DROP_SCORE_EN).
module tb_ingredient_drop_ctrl;

`ifdef DROP_SCORE_EN
    localparam logic SC = 1'b1;
`else
    localparam logic SC = 1'b0;
`endif
    localparam int CHEF_HALF = 8;

    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] ChefX = '0;
    logic [9:0] ChefY = '0;
    logic [9:0] IngrX = 10'd100;
    logic [9:0] IngrY = 10'd200;
    logic       ingr_finish = 1'b0;
    logic       above_falling = 1'b0;
    logic [9:0] AboveY = '0;
    logic       fall;
    logic [3:0] seg_stepped;
    logic       busy;
    logic       done;
    logic       score_pulse;

    always #5 frame_clk = ~frame_clk;

    ingredient_drop_ctrl dut (
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .ChefX         (ChefX),
        .ChefY         (ChefY),
        .IngrX         (IngrX),
        .IngrY         (IngrY),
        .ingr_finish   (ingr_finish),
        .above_falling (above_falling),
        .AboveY        (AboveY),
        .fall          (fall),
        .seg_stepped   (seg_stepped),
        .busy          (busy),
        .done          (done),
        .score_pulse   (score_pulse)
    );

    typedef struct packed {
        logic       score;
        logic       dn;
        logic       bsy;
        logic       fl;
        logic [3:0] seg;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic obs_t ex(input logic sc, input logic d, input logic b,
                                input logic f, input logic [3:0] s);
        obs_t r;
        r.score = sc;
        r.dn    = d;
        r.bsy   = b;
        r.fl    = f;
        r.seg   = s;
        return r;
    endfunction

    task automatic compare(input string tag);
        obs_t e;
        obs_t o;
        e = sb.pop_front();
        o = {score_pulse, done, busy, fall, seg_stepped};
        checks++;
        assert (o === e) begin
            passed++;
            $display("check %-18s score/done/busy/fall/seg=%b ok", tag, o);
        end else begin
            $error("FAIL %s observed=%b expected=%b (score/done/busy/fall/seg)", tag, o, e);
        end
    endtask

    task automatic clk_check(input string tag, input obs_t e);
        sb.push_back(e);
        @(posedge frame_clk);
        #1;
        compare(tag);
    endtask

    task automatic now_check(input string tag, input obs_t e);
        sb.push_back(e);
        compare(tag);
    endtask

    task automatic set_cx(input int cx);
        ChefX = 10'(cx - CHEF_HALF);
    endtask

    initial begin
        #12;
        now_check("reset", ex(0, 0, 0, 0, 4'b0000));
        Reset = 1'b0;

        // Walk one segment per frame across an on-row ingredient.
        ChefY = 10'd184;
        set_cx(100); clk_check("t1_seg0", ex(0, 0, 0, 0, 4'b0001));
        set_cx(108); clk_check("t1_seg1", ex(0, 0, 0, 0, 4'b0011));
        set_cx(116); clk_check("t1_seg2", ex(0, 0, 0, 0, 4'b0111));
        set_cx(124); clk_check("t1_seg3_drop", ex(SC, 0, 1, 1, 4'b1111));

        // Descend one floor.
        ChefY = 10'd0;
        IngrY = 10'd208; clk_check("t2_y208", ex(0, 0, 1, 1, 4'b1111));
        IngrY = 10'd216; clk_check("t2_y216", ex(0, 0, 1, 1, 4'b1111));
        IngrY = 10'd231; clk_check("t2_y231", ex(0, 0, 1, 1, 4'b1111));
        IngrY = 10'd232; clk_check("t2_settle", ex(0, 0, 1, 0, 4'b0000));
        clk_check("t2_idle", ex(0, 0, 0, 0, 4'b0000));

        // Cascade from the ingredient above.
        above_falling = 1'b1;
        AboveY = 10'd233; clk_check("t3_above_below", ex(0, 0, 0, 0, 4'b0000));
        AboveY = 10'd220; clk_check("t3_a220", ex(0, 0, 0, 0, 4'b0000));
        AboveY = 10'd227; clk_check("t3_a227", ex(0, 0, 0, 0, 4'b0000));
        AboveY = 10'd228; clk_check("t3_a228_drop", ex(SC, 0, 1, 1, 4'b0000));
        AboveY = 10'd229; clk_check("t3_a229_hold", ex(0, 0, 1, 1, 4'b0000));
        above_falling = 1'b0;
        IngrY = 10'd264; clk_check("t3_settle", ex(0, 0, 1, 0, 4'b0000));
        clk_check("t3_idle", ex(0, 0, 0, 0, 4'b0000));

        // Chef off the row never steps anything.
        IngrY = 10'd200;
        ChefY = 10'd150;
        for (int cx = 100; cx <= 132; cx += 8) begin
            set_cx(cx);
            clk_check("t4_off_row", ex(0, 0, 0, 0, 4'b0000));
        end

        // Row tolerance and segment edge boundaries.
        ChefY = 10'd187; set_cx(100); clk_check("b_feet_plus3", ex(0, 0, 0, 0, 4'b0000));
        ChefY = 10'd183; set_cx(100); clk_check("b_feet_minus1", ex(0, 0, 0, 0, 4'b0000));
        ChefY = 10'd186; set_cx(100); clk_check("b_feet_plus2", ex(0, 0, 0, 0, 4'b0001));
        ChefY = 10'd184; set_cx(99);  clk_check("b_left_out", ex(0, 0, 0, 0, 4'b0001));
        set_cx(132); clk_check("b_right_out", ex(0, 0, 0, 0, 4'b0001));
        set_cx(115); clk_check("b_seg1_hi", ex(0, 0, 0, 0, 4'b0011));
        set_cx(116); clk_check("b_seg2_lo", ex(0, 0, 0, 0, 4'b0111));
        set_cx(131); clk_check("b_seg3_hi_drop", ex(SC, 0, 1, 1, 4'b1111));

        // Finish during DROP; everything afterwards is ignored.
        ChefY = 10'd0;
        ingr_finish = 1'b1; clk_check("t5_finish", ex(0, 1, 0, 0, 4'b0000));
        ingr_finish = 1'b0;
        ChefY = 10'd184; set_cx(100);
        above_falling = 1'b1; AboveY = 10'd198;
        clk_check("t5_ignore_a", ex(0, 1, 0, 0, 4'b0000));
        clk_check("t5_ignore_b", ex(0, 1, 0, 0, 4'b0000));

        // Reset out of DONE, then forced release by the frame timeout.
        #2 Reset = 1'b1;
        #1 now_check("rst_from_done", ex(0, 0, 0, 0, 4'b0000));
        #1 Reset = 1'b0;
        ChefY = 10'd0;
        clk_check("to_cascade_drop", ex(SC, 0, 1, 1, 4'b0000));
        above_falling = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            clk_check("to_hold", ex(0, 0, 1, 1, 4'b0000));
        end
        clk_check("to_settle", ex(0, 0, 1, 0, 4'b0000));
        clk_check("to_idle", ex(0, 0, 0, 0, 4'b0000));

        // Reset in the middle of a drop clears everything at once.
        ChefY = 10'd184;
        set_cx(100); clk_check("r_seg0", ex(0, 0, 0, 0, 4'b0001));
        set_cx(108); clk_check("r_seg1", ex(0, 0, 0, 0, 4'b0011));
        set_cx(116); clk_check("r_seg2", ex(0, 0, 0, 0, 4'b0111));
        set_cx(124); clk_check("r_seg3_drop", ex(SC, 0, 1, 1, 4'b1111));
        ChefY = 10'd0;
        IngrY = 10'd208; clk_check("r_descend", ex(0, 0, 1, 1, 4'b1111));
        #2 Reset = 1'b1;
        #1 now_check("rst_mid_drop", ex(0, 0, 0, 0, 4'b0000));
        #1 Reset = 1'b0;
        IngrY = 10'd200;
        clk_check("post_reset_idle", ex(0, 0, 0, 0, 4'b0000));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ingredient_drop_ctrl.md
Name: ingredient_drop_ctrl

Overview:
Per-ingredient drop controller; it produces the `fall` request that each ingredient mover consumes.
- Tracks which horizontal segments of one burger ingredient the chef has walked across.
- Asserts `fall` once all segments are stepped, or when the ingredient directly above lands on it (cascade).
- Releases `fall` after the ingredient has descended one floor, or when the ingredient reports finish.
- One instance per ingredient; sits between chef position logic and the ingredient mover.

Parameters:
- NUM_SEG, 4, number of walkable segments per ingredient.
- SEG_W, 8, segment width in pixels; ingredient width = NUM_SEG*SEG_W.
- CHEF_W, 16, chef sprite width in pixels; chef centre X = ChefX + CHEF_W/2.
- CHEF_H, 16, chef sprite height in pixels; feet Y = ChefY + CHEF_H.
- ROW_TOL, 2, feet-to-ingredient-top vertical tolerance in pixels.
- ING_H, 4, ingredient height in pixels, used for the cascade overlap test.
- DROP_DIST, 32, pixels of descent per drop (one floor).
- DROP_TIMEOUT, 255, maximum frames spent in DROP before forced release.

Ports:
- Reset  input  1  asynchronous, active-high reset.
- frame_clk  input  1  clock; one edge per video frame.
- ChefX  input  10  chef top-left X, pixels.
- ChefY  input  10  chef top-left Y, pixels.
- IngrX  input  10  this ingredient's X, pixels (from mover).
- IngrY  input  10  this ingredient's Y, pixels (from mover).
- ingr_finish  input  1  mover reached plate.
- above_falling  input  1  ingredient above is descending.
- AboveY  input  10  ingredient-above Y, pixels.
- fall  output  1  drop request to mover.
- seg_stepped  output  NUM_SEG  per-segment stepped flags; bit 0 = leftmost.
- busy  output  1  high in DROP or SETTLE.
- done  output  1  ingredient finished; sticky until Reset.
- score_pulse  output  1  optional, see Optional Feature.

Behaviour:
Reset values: all outputs 0, state IDLE, internal start_y = 0, timer = 0.

Arithmetic:
- All compares use 11-bit zero-extended intermediates; no wrap.
- on_row: IngrY <= ChefY+CHEF_H <= IngrY+ROW_TOL.
- hit[i]: on_row and IngrX+i*SEG_W <= ChefX+CHEF_W/2 <= IngrX+(i+1)*SEG_W-1.
- cascade: above_falling and AboveY+ING_H >= IngrY and AboveY <= IngrY.

State machine (registered; fall = (state==DROP), busy = DROP|SETTLE):
- IDLE:
  - seg_stepped <= seg_stepped | hit.
  - If ingr_finish, go to DONE (priority 1).
  - Else if cascade, or &(seg_stepped|hit), go to DROP: latch start_y <= IngrY, clear timer.
  - Cascade and final segment in the same frame cause one DROP only.
- DROP:
  - seg_stepped holds its value; timer++.
  - If ingr_finish, go to DONE.
  - Else if IngrY >= start_y+DROP_DIST, or timer == DROP_TIMEOUT, go to SETTLE.
- SETTLE:
  - Lasts exactly one frame; fall=0; seg_stepped <= 0; go to IDLE.
  - A cascade during SETTLE is ignored; it is re-evaluated in IDLE the next frame.
- DONE:
  - done=1, fall=0, seg_stepped=0.
  - All inputs ignored until Reset.

Timing and reset:
- Latency: fall rises on the same edge the last segment is registered, or on which cascade is sampled.
- Reset mid-drop: fall deasserts asynchronously; all state is cleared.
- Chef standing on an already-stepped segment: no effect. Steps are only recorded in IDLE.

Optional Feature:
Macro DROP_SCORE_EN.
- Defined: score_pulse is high for exactly one frame on every IDLE->DROP transition; an extra internal 8-bit saturating count of cascades is kept for debug.
- Undefined: score_pulse is tied 0 and no count logic is generated.

Decomposition:
- Shared package burger_pkg: state enum (IDLE, DROP, SETTLE, DONE), pixel-width constant PIX_W=10, CHEF_W, CHEF_H.
- One sub-module, seg_hit_detect: combinational on_row and per-segment hit vector from chef and ingredient positions.

Test Plan:
1. Ingredient at (100,200), chef at Y=184, centre X walks 100->131 over four frames, one per segment -> seg_stepped 0001, 0011, 0111, then fall=1 on the fourth edge.
2. During DROP, IngrY steps 200->232 -> fall drops on the edge IngrY=232 is sampled, then SETTLE (seg_stepped=0), then IDLE.
3. Idle ingredient at Y=232; above_falling=1 with AboveY ramping to 229 -> fall=1 the frame AboveY reaches 228; seg_stepped stays 0.
4. Chef at Y=150 (off row) crosses all X -> seg_stepped remains 0, fall never asserts.
5. ingr_finish=1 during DROP -> next edge fall=0, done=1; later segment hits ignored.
6. Reset pulsed mid-DROP -> fall, busy and seg_stepped go 0 immediately; with DROP_SCORE_EN, score_pulse is a 1-frame pulse at scenario 1's DROP entry.
